data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 149 ++++++++++++++
 tb/tb_data_memory_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Memory-mapped data responder: a small word RAM plus an input port and an output register,
// served one request at a time with a fixed, parameterised access latency.
module data_memory_responder #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAIT_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  input  logic [7:0]            PortIn,
  output logic [31:0]           PortOut
);

  localparam logic [31:0] RamBase     = 32'h1001_0000;
  localparam logic [31:0] RamBytes    = 32'(MEMORY_DEPTH * 4);
  localparam logic [31:0] PortInAddr  = 32'hFFFF_0000;
  localparam logic [31:0] PortOutAddr = 32'hFFFF_0004;
  localparam int unsigned IdxW        = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [3:0]  WaitInit    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  cap_write_q;
  logic [31:0]           cap_addr_q;
  logic [DATA_WIDTH-1:0] cap_wdata_q;
  logic                  req_ready_q;
  logic                  resp_valid_q;
  logic                  resp_error_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [31:0]           port_out_q;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  enter_resp;
  logic [31:0]           ram_off;
  logic [IdxW-1:0]       ram_idx;
  logic                  ram_hit;
  logic                  ram_we;
  logic                  pout_we;
  logic                  dec_error;
  logic [DATA_WIDTH-1:0] dec_rdata;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign PortOut    = port_out_q;

  // Select the request being completed and decode its target; with zero wait the request is
  // completed straight from the inputs on the accepting edge.
  always_comb begin
    acc_write  = (state_q == StIdle) ? req_write : cap_write_q;
    acc_addr   = (state_q == StIdle) ? req_addr  : cap_addr_q;
    acc_wdata  = (state_q == StIdle) ? req_wdata : cap_wdata_q;
    enter_resp = ((state_q == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                 ((state_q == StBusy) && (cnt_q == 4'd0));
    // Addresses below the base wrap to a huge offset, so one compare bounds both sides.
    ram_off    = acc_addr - RamBase;
    ram_hit    = ram_off < RamBytes;
    ram_idx    = ram_off[IdxW+1:2];
    dec_error  = 1'b1;
    dec_rdata  = '0;
    ram_we     = 1'b0;
    pout_we    = 1'b0;
    if (acc_addr[1:0] != 2'b00) begin
      dec_error = 1'b1;
    end else if (ram_hit) begin
      dec_error = 1'b0;
      if (acc_write) ram_we = 1'b1;
      else           dec_rdata = mem[ram_idx];
    end else if (acc_addr == PortInAddr) begin
      if (!acc_write) begin
        dec_error = 1'b0;
        dec_rdata = DATA_WIDTH'(PortIn);
      end
    end else if (acc_addr == PortOutAddr) begin
      dec_error = 1'b0;
      if (acc_write) pout_we = 1'b1;
      else           dec_rdata = DATA_WIDTH'(port_out_q);
    end
  end

  // Request FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      cap_write_q  <= 1'b0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      port_out_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            cap_write_q <= req_write;
            cap_addr_q  <= req_addr;
            cap_wdata_q <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= StBusy;
            cnt_q       <= WaitInit;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
        StResp: begin
          state_q      <= StIdle;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_error_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
      // Completion overrides the plain transition above; this is the single commit point.
      if (enter_resp) begin
        state_q      <= StResp;
        resp_valid_q <= 1'b1;
        resp_rdata_q <= dec_rdata;
        resp_error_q <= dec_error;
        if (pout_we) port_out_q <= 32'(acc_wdata);
      end
    end
  end

  // RAM store on the completing edge; contents survive reset, which only blocks commits.
  always_ff @(posedge clk or negedge reset) begin
    if (reset && enter_resp && ram_we) mem[ram_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2-cycle and 0-cycle wait) driven with the same
// stimulus and compared each cycle against a transaction-level reference model.
module tb_data_memory_responder;

  localparam int unsigned Depth = 64;
  localparam logic [31:0] Base  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [7:0]  port_in = '0;
  logic [1:0]  ready;
  logic [1:0]  rvalid;
  logic [1:0]  rerr;
  logic [31:0] rdata [2];
  logic [31:0] pout [2];

  always #5 clk = ~clk;

  data_memory_responder #(.MEMORY_DEPTH(Depth), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[0]), .resp_valid(rvalid[0]),
    .resp_rdata(rdata[0]), .resp_error(rerr[0]), .PortIn(port_in), .PortOut(pout[0])
  );

  data_memory_responder #(.MEMORY_DEPTH(Depth), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready[1]), .resp_valid(rvalid[1]),
    .resp_rdata(rdata[1]), .resp_error(rerr[1]), .PortIn(port_in), .PortOut(pout[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_of [2] = '{2, 0};
  int due [2];
  int free_at [2];
  logic [31:0] m_mem [2][Depth];
  logic [31:0] m_pout [2];
  logic        p_write [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic        exp_err [2];
  logic        exp_has_data [2];
  logic [31:0] exp_rdata [2];

  task automatic chk(input string tag, input int u, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s unit%0d cycle %0d: got %h expected %h", tag, u, cyc, got, exp);
    end
  endtask

  // Outcome of a completed access, computed from the address map; commits stores to the model.
  task automatic model_complete(input int u);
    logic [31:0] a;
    int unsigned idx;
    a = p_addr[u];
    exp_err[u] = 1'b1;
    exp_rdata[u] = '0;
    exp_has_data[u] = !p_write[u];
    if (a % 4 != 0) begin
      exp_err[u] = 1'b1;
    end else if (a >= Base && (a - Base) / 4 < Depth) begin
      idx = (a - Base) / 4;
      exp_err[u] = 1'b0;
      if (p_write[u]) m_mem[u][idx] = p_wdata[u];
      else exp_rdata[u] = m_mem[u][idx];
    end else if (a == 32'hFFFF_0000 && !p_write[u]) begin
      exp_err[u] = 1'b0;
      exp_rdata[u] = {24'h0, port_in};
    end else if (a == 32'hFFFF_0004) begin
      exp_err[u] = 1'b0;
      if (p_write[u]) m_pout[u] = p_wdata[u];
      else exp_rdata[u] = m_pout[u];
    end
    if (exp_err[u]) exp_has_data[u] = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model. Entered and left at negedge.
  task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [7:0] p);
    for (int u = 0; u < 2; u++) begin
      chk("req_ready", u, 32'(ready[u]), 32'(cyc >= free_at[u]));
      chk("resp_valid", u, 32'(rvalid[u]), 32'(cyc == due[u]));
      if (cyc == due[u]) begin
        chk("resp_error", u, 32'(rerr[u]), 32'(exp_err[u]));
        if (exp_has_data[u]) chk("resp_rdata", u, rdata[u], exp_rdata[u]);
      end else begin
        chk("quiet_rdata", u, rdata[u], 32'h0);
        chk("quiet_error", u, 32'(rerr[u]), 32'h0);
      end
      chk("PortOut", u, pout[u], m_pout[u]);
    end
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    port_in   = p;
    for (int u = 0; u < 2; u++) begin
      if (v && cyc >= free_at[u]) begin
        p_write[u] = w;
        p_addr[u]  = a;
        p_wdata[u] = d;
        due[u]     = cyc + 1 + wait_of[u];
        free_at[u] = cyc + 2 + wait_of[u];
      end
      if (cyc + 1 == due[u]) model_complete(u);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((cyc < free_at[0] || cyc < free_at[1]) && n < 32) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, port_in);
      n++;
    end
    checks++;
    assert (n < 32) else begin
      errors++;
      $error("FAIL settle_bound cycle %0d: got %0d idle steps expected fewer than 32", cyc, n);
    end
  endtask

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] p);
    step(1'b1, w, a, d, p);
    settle();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < 2; u++) begin
      chk({tag, "_ready"}, u, 32'(ready[u]), 32'h1);
      chk({tag, "_valid"}, u, 32'(rvalid[u]), 32'h0);
      chk({tag, "_rdata"}, u, rdata[u], 32'h0);
      chk({tag, "_error"}, u, 32'(rerr[u]), 32'h0);
      chk({tag, "_PortOut"}, u, pout[u], 32'h0);
    end
  endtask

  // Pull reset mid-cycle (unit 0 is in its wait period), check the asynchronous effect at once.
  task automatic reset_mid();
    req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    reset = 1'b1;
    cyc++;
    for (int u = 0; u < 2; u++) begin
      due[u] = -1;
      free_at[u] = cyc;
      m_pout[u] = '0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom % 7)
      0, 1:    return Base + 4 * ($urandom % Depth);
      2:       return Base + 4 * ($urandom % Depth) + 1 + ($urandom % 3);
      3:       return 32'hFFFF_0000;
      4:       return 32'hFFFF_0004;
      5:       return Base + 4 * Depth;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    for (int u = 0; u < 2; u++) begin
      due[u] = -1;
      free_at[u] = 0;
      m_pout[u] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    cyc = 0;

    for (int i = 0; i < Depth; i++) txn(1'b1, Base + 4 * i, $urandom, 8'h00);

    txn(1'b1, Base + 32'h8, 32'hDEAD_BEEF, 8'h00);
    txn(1'b0, Base + 32'h8, 32'h0, 8'h00);
    txn(1'b0, 32'hFFFF_0000, 32'h0, 8'hA5);
    txn(1'b1, 32'hFFFF_0004, 32'h0000_1234, 8'hA5);
    txn(1'b0, 32'hFFFF_0004, 32'h0, 8'h00);
    txn(1'b0, Base + 32'h2, 32'h0, 8'h00);
    txn(1'b1, 32'h0000_0000, 32'h5555_5555, 8'h00);
    txn(1'b1, 32'hFFFF_0000, 32'h7777_7777, 8'h00);
    txn(1'b1, Base + 4 * Depth, 32'h6666_6666, 8'h00);
    txn(1'b1, 32'hFFFF_0006, 32'h4444_4444, 8'h00);
    txn(1'b0, Base + 32'h8, 32'h0, 8'h00);
    txn(1'b0, 32'hFFFF_0004, 32'h0, 8'h00);

    step(1'b1, 1'b1, 32'hFFFF_0004, 32'hCAFE_F00D, 8'h00);
    reset_mid();
    txn(1'b0, 32'hFFFF_0004, 32'h0, 8'h00);
    step(1'b1, 1'b1, Base + 32'hC, 32'h0BAD_0BAD, 8'h00);
    reset_mid();
    txn(1'b0, Base + 32'hC, 32'h0, 8'h00);

    for (int i = 0; i < 300; i++)
      step(($urandom % 4) != 0, $urandom % 2, rand_addr(), $urandom, 8'($urandom));
    for (int i = 0; i < 80; i++)
      step(1'b1, $urandom % 2, rand_addr(), $urandom, 8'($urandom));
    settle();
    for (int i = 0; i < 8; i++) txn(1'b0, Base + 4 * ($urandom % Depth), 32'h0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
